// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M multiply/divide unit for the EX stage, stalling the front end until done.
// Ports: clk_i/rst_i clock and async active-high reset; start_i/flush_i/op_i/a_i/b_i request;
// result_o/done_o one-cycle result pulse; busy_o not idle; stall_o front-end hold.
module ex_muldiv #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        stall_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    logic [1:0]  state;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q, quo, rem;
    logic [4:0]  cnt;
    logic        div_init;
    logic signed [32:0] ma, mb;
    logic signed [63:0] prod;
    logic [31:0] mul_res, a_mag, b_mag, q_nx, r_nx, q_fix, r_fix, div_res, spec_res;
    logic [32:0] rem_sh, diff;
    logic        signed_div, a_neg, b_neg, div_zero, div_ovf, fits;
    // 33x33 signed product: the extra bit is the operand sign only for the signed flavours
    assign ma = {(op_q == 3'd1 || op_q == 3'd2) & a_q[31], a_q};
    assign mb = {(op_q == 3'd1) & b_q[31], b_q};
    assign prod = $signed({{31{ma[32]}}, ma}) * $signed({{31{mb[32]}}, mb});
    assign mul_res = (op_q == 3'd0) ? prod[31:0] : prod[63:32];
    assign signed_div = ~op_q[0];
    assign a_neg = signed_div & a_q[31];
    assign b_neg = signed_div & b_q[31];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    assign div_zero = (b_q == 32'd0);
    assign div_ovf = signed_div & (a_q == 32'h8000_0000) & (b_q == 32'hffff_ffff);
    // One restoring step: shift the next dividend bit into the partial remainder
    assign rem_sh = {rem, quo[31]};
    assign diff = rem_sh - {1'b0, b_mag};
    assign fits = ~diff[32];
    assign q_nx = {quo[30:0], fits};
    assign r_nx = fits ? diff[31:0] : rem_sh[31:0];
    assign q_fix = (a_neg ^ b_neg) ? -q_nx : q_nx;
    assign r_fix = a_neg ? -r_nx : r_nx;
    assign div_res = op_q[1] ? r_fix : q_fix;
    assign spec_res = div_zero ? (op_q[1] ? a_q : 32'hffff_ffff) : (op_q[1] ? 32'd0 : 32'h8000_0000);
    assign done_o = (state == DONE);
    assign busy_o = (state != IDLE);
    assign stall_o = start_i & ~done_o & ~flush_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            quo      <= 32'd0;
            rem      <= 32'd0;
            cnt      <= 5'd0;
            div_init <= 1'b0;
            result_o <= 32'd0;
        end else if (flush_i) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    op_q     <= op_i;
                    a_q      <= a_i;
                    b_q      <= b_i;
                    cnt      <= 5'd0;
                    div_init <= 1'b1;
                    state    <= op_i[2] ? DIV : MUL;
                end
                MUL: if (cnt == 5'(MUL_LATENCY - 1)) begin
                    state    <= DONE;
                    cnt      <= 5'd0;
                    result_o <= mul_res;
                end else begin
                    cnt <= cnt + 5'd1;
                end
                // First DIV cycle resolves special cases or loads the dividend magnitude
                DIV: if (div_init) begin
                    div_init <= 1'b0;
                    if (div_zero || div_ovf) begin
                        state    <= DONE;
                        result_o <= spec_res;
                    end else begin
                        quo <= a_mag;
                        rem <= 32'd0;
                    end
                end else begin
                    quo <= q_nx;
                    rem <= r_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state    <= DONE;
                        result_o <= div_res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed scoreboard bench for ex_muldiv with latency, flush and reset checks.
module tb_ex_muldiv;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i, result_o;
    logic        done_o, busy_o, stall_o;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    ex_muldiv #(.MUL_LATENCY(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
        .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .result_o(result_o), .done_o(done_o), .busy_o(busy_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit hold);
        int n;
        logic [31:0] e;
        int l;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b; flush_i = 1'b0;
        n = 0;
        while (busy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        n = 0;
        if (!hold) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        do begin
            @(posedge clk_i);
            #1;
            n++;
            if (!done_o && hold) chk("stall_wait", 32'(stall_o), 32'd1);
        end while (!done_o && n < 60);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("done", 32'(done_o), 32'd1);
        chk("result", result_o, e);
        chk("latency", 32'(n), 32'(l));
        if (hold) chk("stall_done", 32'(stall_o), 32'd0);
    endtask

    task automatic no_done(input int cycles, input string tag);
        int c = 0;
        repeat (cycles) begin
            @(posedge clk_i);
            #1;
            c += int'(done_o);
        end
        chk(tag, 32'(c), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b1; flush_i = 1'b0; op_i = 3'd0; a_i = 32'd0; b_i = 32'd0;
        #2;
        chk("rst_result", result_o, 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd1);
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        do_op(3'd0, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, 2, 1'b1);
        do_op(3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 2, 1'b1);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 1'b1);
        do_op(3'd2, 32'hffff_ffff, 32'd2, 32'hffff_ffff, 2, 1'b1);
        do_op(3'd4, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 33, 1'b1);
        do_op(3'd6, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 33, 1'b1);
        do_op(3'd5, 32'd5, 32'd0, 32'hffff_ffff, 1, 1'b1);
        do_op(3'd7, 32'd5, 32'd0, 32'd5, 1, 1'b1);
        do_op(3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1, 1'b1);
        do_op(3'd6, 32'h8000_0000, 32'hffff_ffff, 32'd0, 1, 1'b1);
        do_op(3'd4, 32'd7, 32'hffff_fffe, 32'hffff_fffd, 33, 1'b1);
        do_op(3'd6, 32'd7, 32'hffff_fffe, 32'd1, 33, 1'b1);
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, 1'b1);
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("hold_result", result_o, 32'd14);
        chk("hold_done", 32'(done_o), 32'd0);
        // flush during divide iterations
        @(negedge clk_i);
        start_i = 1'b1; op_i = 3'd5; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk_i);
        repeat (11) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        #1 chk("flush_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        flush_i = 1'b0; start_i = 1'b0;
        no_done(40, "flush_no_done");
        do_op(3'd0, 32'd3, 32'd4, 32'd12, 2, 1'b1);
        // async reset during divide
        @(negedge clk_i);
        start_i = 1'b1; op_i = 3'd5; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk_i);
        repeat (5) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        chk("arst_result", result_o, 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        no_done(40, "arst_no_done");
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        do_op(3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 2, 1'b1);
        @(negedge clk_i);
        start_i = 1'b0;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
